// File: rtl/conversor_andar_histerese.sv
// BCD distance (cm) to lift floor tracker: two-stage pipeline, hysteresis dead band, N-sample filter.
// Optional motion outputs (subindo/descendo/parado) are built when CONVERSOR_MOVIMENTO_EN is defined.
`timescale 1ns/1ps
module conversor_andar_histerese #(
    parameter int N_ANDARES    = 4,
    parameter int ALTURA_ANDAR = 30,
    parameter int HISTERESE    = 3,
    parameter int N_ESTAVEL    = 3,
    localparam int W = (N_ANDARES > 1) ? $clog2(N_ANDARES) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         medida_pronto,
    input  logic [3:0]   unidades,
    input  logic [3:0]   dezenas,
    input  logic [3:0]   centenas,
    output logic [W-1:0] andar,
    output logic         andar_valido,
    output logic         mudou_andar,
    output logic         em_transicao,
    output logic         fora_faixa,
`ifdef CONVERSOR_MOVIMENTO_EN
    output logic         subindo,
    output logic         descendo,
    output logic         parado,
`endif
    output logic         erro_bcd
);

    typedef enum logic [1:0] {INICIAL, ESTAVEL, CONFIRMANDO} estado_t;

    // ---------------- stage 1: BCD validation and conversion ----------------
    logic       bcd_ok;
    logic [9:0] altura_bin;
    logic       s1_valid_reg;
    logic [9:0] s1_altura_reg;
    logic       erro_bcd_reg;

    assign bcd_ok     = (unidades <= 4'd9) && (dezenas <= 4'd9) && (centenas <= 4'd9);
    assign altura_bin = {6'b0, centenas} * 10'd100 + {6'b0, dezenas} * 10'd10 + {6'b0, unidades};

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_altura_reg <= '0;
            erro_bcd_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= medida_pronto && bcd_ok;
            erro_bcd_reg <= medida_pronto && !bcd_ok;
            if (medida_pronto && bcd_ok)
                s1_altura_reg <= altura_bin;
        end
    end

    // ---------------- stage 2: floor candidate via comparator chain ----------------
    logic [31:0]          alt32;
    logic [N_ANDARES-1:0] ge_piso;
    logic [N_ANDARES-1:0] ok_sobe;
    logic [N_ANDARES-1:0] ok_desce;
    logic                 fora;
    logic [W-1:0]         cand;

    assign alt32 = {22'b0, s1_altura_reg};
    assign fora  = alt32 >= 32'(N_ANDARES * ALTURA_ANDAR);

    // Per-floor thresholds: floor base, upward dead-band edge, downward dead-band edge.
    generate
        for (genvar gi = 0; gi < N_ANDARES; gi++) begin : g_limiar
            assign ge_piso[gi]  = alt32 >= 32'(gi * ALTURA_ANDAR);
            assign ok_sobe[gi]  = alt32 >= 32'(gi * ALTURA_ANDAR + HISTERESE);
            assign ok_desce[gi] = alt32 <  32'((gi + 1) * ALTURA_ANDAR - HISTERESE);
        end
    endgenerate

    always_comb begin
        cand = '0;
        for (int k = 0; k < N_ANDARES; k++)
            if (ge_piso[k])
                cand = W'(k);
    end

    // ---------------- floor FSM ----------------
    estado_t      state_reg, state_next;
    logic [W-1:0] pending_reg, pending_next;
    logic [3:0]   count_reg, count_next;
    logic [W-1:0] andar_reg, andar_next;
    logic         valido_reg, valido_next;
    logic         mudou_reg, mudou_next;
    logic         fora_reg, fora_next;
    logic         em_transicao_reg;
    logic         aceito;
    logic [3:0]   cnt_inc;

    assign aceito  = ((cand > andar_reg) && ok_sobe[cand]) ||
                     ((cand < andar_reg) && ok_desce[cand]);
    assign cnt_inc = ((count_reg != 4'd0) && (cand == pending_reg)) ? count_reg + 4'd1 : 4'd1;

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        count_next   = count_reg;
        andar_next   = andar_reg;
        valido_next  = valido_reg;
        mudou_next   = 1'b0;
        fora_next    = fora_reg;
        if (s1_valid_reg) begin
            if (fora) begin
                fora_next  = 1'b1;
                count_next = 4'd0;
                if (state_reg != INICIAL)
                    state_next = ESTAVEL;
            end else begin
                fora_next = 1'b0;
                case (state_reg)
                    INICIAL: begin
                        if (cnt_inc == 4'(N_ESTAVEL)) begin
                            andar_next  = cand;
                            valido_next = 1'b1;
                            mudou_next  = 1'b1;
                            count_next  = 4'd0;
                            state_next  = ESTAVEL;
                        end else begin
                            pending_next = cand;
                            count_next   = cnt_inc;
                        end
                    end
                    ESTAVEL: begin
                        if (aceito) begin
                            if (N_ESTAVEL == 1) begin
                                andar_next = cand;
                                mudou_next = 1'b1;
                                count_next = 4'd0;
                            end else begin
                                pending_next = cand;
                                count_next   = 4'd1;
                                state_next   = CONFIRMANDO;
                            end
                        end else begin
                            count_next = 4'd0;
                        end
                    end
                    CONFIRMANDO: begin
                        if (aceito) begin
                            if (cnt_inc == 4'(N_ESTAVEL)) begin
                                andar_next = cand;
                                mudou_next = 1'b1;
                                count_next = 4'd0;
                                state_next = ESTAVEL;
                            end else begin
                                pending_next = cand;
                                count_next   = cnt_inc;
                            end
                        end else begin
                            count_next = 4'd0;
                            state_next = ESTAVEL;
                        end
                    end
                    default: begin
                        count_next = 4'd0;
                        state_next = INICIAL;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= INICIAL;
            pending_reg      <= '0;
            count_reg        <= 4'd0;
            andar_reg        <= '0;
            valido_reg       <= 1'b0;
            mudou_reg        <= 1'b0;
            fora_reg         <= 1'b0;
            em_transicao_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pending_reg      <= pending_next;
            count_reg        <= count_next;
            andar_reg        <= andar_next;
            valido_reg       <= valido_next;
            mudou_reg        <= mudou_next;
            fora_reg         <= fora_next;
            em_transicao_reg <= (state_next == CONFIRMANDO);
        end
    end

    assign andar        = andar_reg;
    assign andar_valido = valido_reg;
    assign mudou_andar  = mudou_reg;
    assign em_transicao = em_transicao_reg;
    assign fora_faixa   = fora_reg;
    assign erro_bcd     = erro_bcd_reg;

`ifdef CONVERSOR_MOVIMENTO_EN
    // ---------------- motion direction vs previous in-range sample ----------------
    localparam logic signed [11:0] HIST_S = 12'(HISTERESE);

    logic [9:0]         prev_altura_reg;
    logic               prev_valid_reg;
    logic               subindo_reg, descendo_reg, parado_reg;
    logic signed [11:0] dif;

    assign dif = $signed({2'b00, s1_altura_reg}) - $signed({2'b00, prev_altura_reg});

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_altura_reg <= '0;
            prev_valid_reg  <= 1'b0;
            subindo_reg     <= 1'b0;
            descendo_reg    <= 1'b0;
            parado_reg      <= 1'b0;
        end else if (s1_valid_reg && !fora) begin
            prev_altura_reg <= s1_altura_reg;
            prev_valid_reg  <= 1'b1;
            if (prev_valid_reg) begin
                subindo_reg  <= (dif > HIST_S);
                descendo_reg <= (dif < -HIST_S);
                parado_reg   <= !(dif > HIST_S) && !(dif < -HIST_S);
            end
        end
    end

    assign subindo  = subindo_reg;
    assign descendo = descendo_reg;
    assign parado   = parado_reg;
`endif

endmodule

// File: tb/tb_conversor_andar_histerese.sv
// Directed bench for conversor_andar_histerese: expectations queued per strobe, checked when due.
`timescale 1ns/1ps
module tb_conversor_andar_histerese;

    localparam int N_ANDARES    = 4;
    localparam int ALTURA_ANDAR = 30;
    localparam int HISTERESE    = 3;
    localparam int N_ESTAVEL    = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       medida_pronto;
    logic [3:0] unidades, dezenas, centenas;
    logic [1:0] andar;
    logic       andar_valido, mudou_andar, em_transicao, fora_faixa, erro_bcd;
`ifdef CONVERSOR_MOVIMENTO_EN
    logic       subindo, descendo, parado;
`endif

    conversor_andar_histerese #(
        .N_ANDARES   (N_ANDARES),
        .ALTURA_ANDAR(ALTURA_ANDAR),
        .HISTERESE   (HISTERESE),
        .N_ESTAVEL   (N_ESTAVEL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .medida_pronto(medida_pronto),
        .unidades     (unidades),
        .dezenas      (dezenas),
        .centenas     (centenas),
        .andar        (andar),
        .andar_valido (andar_valido),
        .mudou_andar  (mudou_andar),
        .em_transicao (em_transicao),
        .fora_faixa   (fora_faixa),
`ifdef CONVERSOR_MOVIMENTO_EN
        .subindo      (subindo),
        .descendo     (descendo),
        .parado       (parado),
`endif
        .erro_bcd     (erro_bcd)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        int         step;
        logic [1:0] a;
        logic       v, m, t, f;
        logic       s, d, p;
    } exp_t;

    typedef struct {
        int   due;
        int   step;
        logic e;
    } err_t;

    exp_t sb[$];
    err_t eq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    // motion reference state
    int   prev_alt  = 0;
    bit   have_prev = 0;
    logic ms = 0, md = 0, mp = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            $display("step %0d: andar=%0d valido=%0b mudou=%0b em=%0b fora=%0b", e.step,
                     andar, andar_valido, mudou_andar, em_transicao, fora_faixa);
            check($sformatf("andar[%0d]", e.step), 32'(andar), 32'(e.a));
            check($sformatf("andar_valido[%0d]", e.step), 32'(andar_valido), 32'(e.v));
            check($sformatf("mudou_andar[%0d]", e.step), 32'(mudou_andar), 32'(e.m));
            check($sformatf("em_transicao[%0d]", e.step), 32'(em_transicao), 32'(e.t));
            check($sformatf("fora_faixa[%0d]", e.step), 32'(fora_faixa), 32'(e.f));
`ifdef CONVERSOR_MOVIMENTO_EN
            check($sformatf("subindo[%0d]", e.step), 32'(subindo), 32'(e.s));
            check($sformatf("descendo[%0d]", e.step), 32'(descendo), 32'(e.d));
            check($sformatf("parado[%0d]", e.step), 32'(parado), 32'(e.p));
`endif
        end
        while (eq.size() > 0 && eq[0].due == cyc) begin
            err_t r;
            r = eq.pop_front();
            check($sformatf("erro_bcd[%0d]", r.step), 32'(erro_bcd), 32'(r.e));
        end
    end

    // One strobe; caller supplies the stage-2 outputs expected two edges after sampling.
    task automatic smp(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                       input logic [1:0] ea, input logic ev, input logic em_,
                       input logic et, input logic ef);
        exp_t e;
        err_t r;
        bit   ok;
        int   alt, dif;
        ok  = (c <= 4'd9) && (d <= 4'd9) && (u <= 4'd9);
        alt = int'(c) * 100 + int'(d) * 10 + int'(u);
        if (ok && alt < N_ANDARES * ALTURA_ANDAR) begin
            if (have_prev) begin
                dif = alt - prev_alt;
                ms  = dif > HISTERESE;
                md  = dif < -HISTERESE;
                mp  = !ms && !md;
            end
            prev_alt  = alt;
            have_prev = 1;
        end
        step++;
        centenas      = c;
        dezenas       = d;
        unidades      = u;
        medida_pronto = 1'b1;
        e.due = cyc + 2; e.step = step;
        e.a = ea; e.v = ev; e.m = em_; e.t = et; e.f = ef;
        e.s = ms; e.d = md; e.p = mp;
        sb.push_back(e);
        r.due = cyc + 1; r.step = step; r.e = !ok;
        eq.push_back(r);
        @(posedge clock); #1;
        medida_pronto = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset         = 1'b1;
        medida_pronto = 1'b0;
        unidades      = 4'd0;
        dezenas       = 4'd0;
        centenas      = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_andar", 32'(andar), 32'd0);
        check("rst_valido", 32'(andar_valido), 32'd0);
        check("rst_mudou", 32'(mudou_andar), 32'd0);
        check("rst_em", 32'(em_transicao), 32'd0);
        check("rst_fora", 32'(fora_faixa), 32'd0);
        check("rst_erro", 32'(erro_bcd), 32'd0);
        reset = 1'b0;
        idle(1);

        // first floor from INICIAL: 45 cm x3
        smp(0, 4, 5,  2'd0, 0, 0, 0, 0);
        smp(0, 4, 5,  2'd0, 0, 0, 0, 0);
        smp(0, 4, 5,  2'd1, 1, 1, 0, 0);
        // 61 cm inside dead band above floor 1
        smp(0, 6, 1,  2'd1, 1, 0, 0, 0);
        smp(0, 6, 1,  2'd1, 1, 0, 0, 0);
        smp(0, 6, 1,  2'd1, 1, 0, 0, 0);
        // 64 cm past dead band
        smp(0, 6, 4,  2'd1, 1, 0, 1, 0);
        smp(0, 6, 4,  2'd1, 1, 0, 1, 0);
        smp(0, 6, 4,  2'd2, 1, 1, 0, 0);
        // 55, 64 (return clears count), 55 x3
        smp(0, 5, 5,  2'd2, 1, 0, 1, 0);
        smp(0, 6, 4,  2'd2, 1, 0, 0, 0);
        smp(0, 5, 5,  2'd2, 1, 0, 1, 0);
        smp(0, 5, 5,  2'd2, 1, 0, 1, 0);
        smp(0, 5, 5,  2'd1, 1, 1, 0, 0);
        // out of range, bad BCD (outputs held), back in range
        smp(1, 3, 0,  2'd1, 1, 0, 0, 1);
        smp(0, 4, 4'hA, 2'd1, 1, 0, 0, 1);
        smp(0, 4, 5,  2'd1, 1, 0, 0, 0);
        // out-of-range sample during confirmation restarts the count
        smp(0, 6, 4,  2'd1, 1, 0, 1, 0);
        smp(1, 3, 0,  2'd1, 1, 0, 0, 1);
        smp(0, 6, 4,  2'd1, 1, 0, 1, 0);
        smp(0, 6, 4,  2'd1, 1, 0, 1, 0);
        smp(0, 6, 4,  2'd2, 1, 1, 0, 0);
        // range boundary: 120 out, 119 is top floor; gaps between strobes
        smp(1, 2, 0,  2'd2, 1, 0, 0, 1);
        smp(1, 1, 9,  2'd2, 1, 0, 1, 0);
        idle(3);
        smp(1, 1, 9,  2'd2, 1, 0, 1, 0);
        smp(1, 1, 9,  2'd3, 1, 1, 0, 0);
        // bad hundreds digit
        smp(4'hF, 0, 0, 2'd3, 1, 0, 0, 0);
        // 40, 50, 49 -> floor 1; 30 stays
        smp(0, 4, 0,  2'd3, 1, 0, 1, 0);
        smp(0, 5, 0,  2'd3, 1, 0, 1, 0);
        smp(0, 4, 9,  2'd1, 1, 1, 0, 0);
        smp(0, 3, 0,  2'd1, 1, 0, 0, 0);

        idle(4);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("eq_drained", 32'(eq.size()), 32'd0);

        reset = 1'b1;
        idle(1);
        check("rst2_andar", 32'(andar), 32'd0);
        check("rst2_valido", 32'(andar_valido), 32'd0);
        check("rst2_fora", 32'(fora_faixa), 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
